// File: rtl/rect_draw_scheduler.sv
// Shares one rectangle rasterizer among NUM_REQ requesters once per frame pass.
// Requesters are serviced in ascending index order, so higher indices paint over lower ones.
module rect_draw_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [9*NUM_REQ-1:0]   req_x,
  input  logic [8*NUM_REQ-1:0]   req_y,
  input  logic [9*NUM_REQ-1:0]   req_L,
  input  logic [8*NUM_REQ-1:0]   req_W,
  input  logic [3*NUM_REQ-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   eng_start,
  output logic [8:0]             eng_x,
  output logic [7:0]             eng_y,
  output logic [8:0]             eng_L,
  output logic [7:0]             eng_W,
  output logic [2:0]             eng_colour,
  input  logic                   eng_done,
  output logic                   pass_busy,
  output logic                   pass_done,
  output logic                   timeout_err,
  output logic                   overrun
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LOAD,
    S_START,
    S_WAIT,
    S_ACK,
    S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WD_W-1:0]  wd, wd_nxt;
  logic             load_en;
  logic             tmo_fire;
  logic             last_idx;

  logic             sel_req;
  logic [8:0]       sel_x;
  logic [7:0]       sel_y;
  logic [8:0]       sel_L;
  logic [7:0]       sel_W;
  logic [2:0]       sel_colour;

  // Slice out the descriptor of the requester currently pointed at by idx
  always_comb begin
    sel_req    = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_L      = '0;
    sel_W      = '0;
    sel_colour = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_req    = req[i];
        sel_x      = req_x[9*i +: 9];
        sel_y      = req_y[8*i +: 8];
        sel_L      = req_L[9*i +: 9];
        sel_W      = req_W[8*i +: 8];
        sel_colour = req_colour[3*i +: 3];
      end
    end
  end

  assign last_idx = (idx == IDX_LAST);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      wd    <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wd_nxt    = wd;
    load_en   = 1'b0;
    tmo_fire  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nxt = S_SCAN;
          idx_nxt   = '0;
        end
      end
      S_SCAN: begin
        if (sel_req) begin
          state_nxt = S_LOAD;
        end else if (last_idx) begin
          state_nxt = S_FINISH;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        // Degenerate rectangles draw nothing, so the engine is never bothered
        if (sel_L == '0 || sel_W == '0) begin
          state_nxt = S_ACK;
        end else begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        wd_nxt    = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wd_nxt = wd + WD_W'(1);
        if (eng_done) begin
          state_nxt = S_ACK;
        end else if (wd == WD_LAST) begin
          // Hung engine: drop this requester without an ack and move on
          tmo_fire = 1'b1;
          if (last_idx) begin
            state_nxt = S_FINISH;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_SCAN;
          end
        end
      end
      S_ACK: begin
        if (last_idx) begin
          state_nxt = S_FINISH;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = S_SCAN;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Descriptor latch: held from LOAD until the next LOAD, including after the pass
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      eng_x      <= '0;
      eng_y      <= '0;
      eng_L      <= '0;
      eng_W      <= '0;
      eng_colour <= '0;
    end else if (load_en) begin
      eng_x      <= sel_x;
      eng_y      <= sel_y;
      eng_L      <= sel_L;
      eng_W      <= sel_W;
      eng_colour <= sel_colour;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (tmo_fire) begin
        timeout_err <= 1'b1;
      end
      if (frame_start && state != S_IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state == S_ACK) && (idx == IDX_W'(i));
    end
  end

  assign eng_start = (state == S_START);
  assign pass_busy = (state != S_IDLE);
  assign pass_done = (state == S_FINISH);

  ack_onehot: assert property (@(posedge clock) disable iff (!rst) $onehot0(ack));
  start_single: assert property (@(posedge clock) disable iff (!rst) eng_start |=> !eng_start);

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Bench for rect_draw_scheduler: directed table rows, hand-written corner sequences and
// randomized passes checked cycle by cycle against a timeline model of the pass.
module tb_rect_draw_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam int MAXC = 128;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        frame_start = 1'b0;
  logic [3:0]  req = '0;
  logic [35:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic [35:0] req_L = '0;
  logic [31:0] req_W = '0;
  logic [11:0] req_colour = '0;
  logic [3:0]  ack;
  logic        eng_start;
  logic [8:0]  eng_x;
  logic [7:0]  eng_y;
  logic [8:0]  eng_L;
  logic [7:0]  eng_W;
  logic [2:0]  eng_colour;
  logic        eng_done = 1'b0;
  logic        pass_busy;
  logic        pass_done;
  logic        timeout_err;
  logic        overrun;

  rect_draw_scheduler #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .rst(rst), .frame_start(frame_start), .req(req),
    .req_x(req_x), .req_y(req_y), .req_L(req_L), .req_W(req_W), .req_colour(req_colour),
    .ack(ack), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_L(eng_L),
    .eng_W(eng_W), .eng_colour(eng_colour), .eng_done(eng_done), .pass_busy(pass_busy),
    .pass_done(pass_done), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [8:0] dx[4];
  logic [7:0] dy[4];
  logic [8:0] dL[4];
  logic [7:0] dW[4];
  logic [2:0] dc[4];
  int         dly[4];

  bit         m_start[MAXC];
  logic [3:0] m_ack[MAXC];
  bit         m_busy[MAXC];
  bit         m_pdone[MAXC];
  bit         m_wait[MAXC];
  int         m_desc[MAXC];
  int         scan_c[4];
  int         m_tmo_c;
  int         last_loaded;
  int         fin;
  int         dq[$];
  int         eng_cnt = 0;

  bit          exp_tmo = 0;
  bit          exp_ovr = 0;
  logic [36:0] exp_eng = '0;

  int         meas_first;
  int         meas_pd;
  logic [3:0] meas_acks;

  typedef struct {
    logic [3:0] rq;
    int         delay;
    logic [3:0] zm;
    int         e_first;
    int         e_pd;
    logic [3:0] e_acks;
    bit         e_tmo;
  } row_t;
  row_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [36:0] desc_word(input int i);
    return {dx[i], dy[i], dL[i], dW[i], dc[i]};
  endfunction

  function automatic logic [36:0] eng_word();
    return {eng_x, eng_y, eng_L, eng_W, eng_colour};
  endfunction

  task automatic apply_desc();
    for (int i = 0; i < 4; i++) begin
      req_x[9*i +: 9]      = dx[i];
      req_y[8*i +: 8]      = dy[i];
      req_L[9*i +: 9]      = dL[i];
      req_W[8*i +: 8]      = dW[i];
      req_colour[3*i +: 3] = dc[i];
    end
  endtask

  task automatic base_desc();
    for (int i = 0; i < 4; i++) begin
      dx[i]  = 9'(30 * i + 7);
      dy[i]  = 8'(20 * i + 3);
      dL[i]  = 9'(5 + i);
      dW[i]  = 8'(4 + i);
      dc[i]  = 3'(i + 1);
      dly[i] = 3;
    end
    dx[2] = 9'd100; dy[2] = 8'd50; dL[2] = 9'd20; dW[2] = 8'd10; dc[2] = 3'b010;
  endtask

  // Caller positions itself away from the rising edge; reset takes effect asynchronously.
  task automatic do_reset();
    rst = 1'b0;
    frame_start = 1'b0;
    eng_done = 1'b0;
    req = '0;
    #1;
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_eng_start", 64'(eng_start), 64'(0));
    chk("rst_busy", 64'(pass_busy), 64'(0));
    chk("rst_pass_done", 64'(pass_done), 64'(0));
    chk("rst_timeout", 64'(timeout_err), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_eng_desc", 64'(eng_word()), 64'(0));
    repeat (2) @(negedge clock);
    rst = 1'b1;
    exp_tmo = 0;
    exp_ovr = 0;
    exp_eng = '0;
    eng_cnt = 0;
    dq.delete();
  endtask

  // Timeline of a pass, cycle 0 being the cycle frame_start is high.
  task automatic build_model(input logic [3:0] rq);
    int cur, st, d;
    for (int c = 0; c < MAXC; c++) begin
      m_start[c] = 0; m_ack[c] = '0; m_busy[c] = 0; m_pdone[c] = 0;
      m_wait[c] = 0; m_desc[c] = -1;
    end
    m_tmo_c = -1;
    last_loaded = -1;
    dq.delete();
    cur = 1;
    for (int i = 0; i < 4; i++) begin
      scan_c[i] = cur;
      if (!rq[i]) begin
        cur = cur + 1;
      end else begin
        last_loaded = i;
        if (dL[i] == 0 || dW[i] == 0) begin
          m_ack[cur+2][i] = 1'b1;
          m_desc[cur+2] = i;
          cur = cur + 3;
        end else begin
          st = cur + 2;
          d = dly[i];
          m_start[st] = 1;
          dq.push_back(d);
          if (d >= 1 && d <= TMO) begin
            for (int k = 1; k <= d; k++) m_wait[st+k] = 1;
            for (int k = 0; k <= d + 1; k++) m_desc[st+k] = i;
            m_ack[st+d+1][i] = 1'b1;
            cur = st + d + 2;
          end else begin
            for (int k = 1; k <= TMO; k++) m_wait[st+k] = 1;
            for (int k = 0; k <= TMO; k++) m_desc[st+k] = i;
            if (m_tmo_c < 0) m_tmo_c = st + TMO + 1;
            cur = st + TMO + 1;
          end
        end
      end
    end
    fin = cur;
    m_pdone[fin] = 1;
    for (int c = 1; c <= fin; c++) m_busy[c] = 1;
  endtask

  task automatic do_pass(input logic [3:0] rq, input bit drop, input bit stray, input bit ov_en);
    int ov_c, d;
    apply_desc();
    build_model(rq);
    if (fin + 2 > MAXC) begin
      $display("FAIL model_range: got %0d expected below %0d", fin + 2, MAXC);
      $fatal(1, "model range");
    end
    ov_c = ov_en ? int'($urandom_range(1, fin)) : -1;
    meas_first = -1;
    meas_pd = -1;
    meas_acks = '0;
    for (int c = 0; c <= fin + 1; c++) begin
      @(posedge clock);
      #1;
      frame_start = (c == 0) || (c == ov_c);
      for (int i = 0; i < 4; i++) req[i] = rq[i] && !(drop && c > scan_c[i]);
      eng_done = 1'b0;
      if (eng_cnt > 0) begin
        if (eng_cnt == 1) eng_done = 1'b1;
        eng_cnt--;
      end else if (stray && !m_wait[c] && $urandom_range(0, 3) == 0) begin
        eng_done = 1'b1;
      end
      @(negedge clock);
      if (c == m_tmo_c) exp_tmo = 1;
      if (ov_c >= 0 && c == ov_c + 1) exp_ovr = 1;
      chk("eng_start", 64'(eng_start), 64'(m_start[c]));
      chk("ack", 64'(ack), 64'(m_ack[c]));
      chk("pass_done", 64'(pass_done), 64'(m_pdone[c]));
      chk("pass_busy", 64'(pass_busy), 64'(m_busy[c]));
      chk("timeout_err", 64'(timeout_err), 64'(exp_tmo));
      chk("overrun", 64'(overrun), 64'(exp_ovr));
      if (m_desc[c] >= 0) chk("eng_desc", 64'(eng_word()), 64'(desc_word(m_desc[c])));
      if (eng_start && meas_first < 0) meas_first = c;
      if (pass_done && meas_pd < 0) meas_pd = c;
      meas_acks = meas_acks | ack;
      if (eng_start) begin
        d = (dq.size() > 0) ? dq.pop_front() : 0;
        eng_cnt = (d >= 1) ? d : 0;
      end
    end
    frame_start = 1'b0;
    eng_done = 1'b0;
    if (last_loaded >= 0) exp_eng = desc_word(last_loaded);
    chk("eng_hold", 64'(eng_word()), 64'(exp_eng));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{rq: 4'b0000, delay: 3,  zm: 4'b0000, e_first: -1, e_pd: 5,  e_acks: 4'b0000, e_tmo: 0};
    tbl[1] = '{rq: 4'b0100, delay: 10, zm: 4'b0000, e_first: 5,  e_pd: 18, e_acks: 4'b0100, e_tmo: 0};
    tbl[2] = '{rq: 4'b1111, delay: 3,  zm: 4'b0000, e_first: 3,  e_pd: 29, e_acks: 4'b1111, e_tmo: 0};
    tbl[3] = '{rq: 4'b0010, delay: 3,  zm: 4'b0010, e_first: -1, e_pd: 7,  e_acks: 4'b0010, e_tmo: 0};
    tbl[4] = '{rq: 4'b0001, delay: 0,  zm: 4'b0000, e_first: 3,  e_pd: 23, e_acks: 4'b0000, e_tmo: 1};
    tbl[5] = '{rq: 4'b0001, delay: 16, zm: 4'b0000, e_first: 3,  e_pd: 24, e_acks: 4'b0001, e_tmo: 0};
    tbl[6] = '{rq: 4'b0110, delay: 3,  zm: 4'b0010, e_first: 7,  e_pd: 13, e_acks: 4'b0110, e_tmo: 0};

    @(negedge clock);
    do_reset();

    for (int r = 0; r < 7; r++) begin
      base_desc();
      for (int i = 0; i < 4; i++) begin
        dly[i] = tbl[r].delay;
        if (tbl[r].zm[i]) dL[i] = '0;
      end
      @(negedge clock);
      do_reset();
      do_pass(tbl[r].rq, 0, 0, 0);
      chk("tbl_first_start", 64'(meas_first), 64'(tbl[r].e_first));
      chk("tbl_pass_done_cyc", 64'(meas_pd), 64'(tbl[r].e_pd));
      chk("tbl_acks", 64'(meas_acks), 64'(tbl[r].e_acks));
      chk("tbl_timeout", 64'(timeout_err), 64'(tbl[r].e_tmo));
    end

    // Second frame_start mid-pass: flagged, pass unaffected
    base_desc();
    @(negedge clock);
    do_reset();
    do_pass(4'b1010, 0, 0, 1);
    chk("overrun_set", 64'(overrun), 64'(1));
    do_pass(4'b0001, 0, 0, 0);
    chk("overrun_sticky", 64'(overrun), 64'(1));

    // Reset while the engine is busy, then a clean restart from index 0
    base_desc();
    dly[0] = 0;
    apply_desc();
    for (int c = 0; c <= 8; c++) begin
      @(posedge clock);
      #1;
      frame_start = (c == 0);
      req = 4'b0001;
      @(negedge clock);
    end
    chk("wait_busy", 64'(pass_busy), 64'(1));
    do_reset();
    base_desc();
    do_pass(4'b0001, 0, 0, 0);
    chk("restart_first_start", 64'(meas_first), 64'(3));
    chk("restart_acks", 64'(meas_acks), 64'(4'b0001));

    // Randomized passes
    for (int p = 0; p < 40; p++) begin
      if (p % 10 == 0) begin
        @(negedge clock);
        do_reset();
      end
      for (int i = 0; i < 4; i++) begin
        dx[i] = 9'($urandom_range(0, 511));
        dy[i] = 8'($urandom_range(0, 255));
        dL[i] = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
        dW[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        dc[i] = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          0:       dly[i] = 0;
          1:       dly[i] = TMO;
          2:       dly[i] = $urandom_range(9, TMO);
          default: dly[i] = $urandom_range(1, 8);
        endcase
      end
      do_pass(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
